// File: rtl/wb_grf.sv
// wb_grf: MIPS write-back stage and 32x32 general register file.
// Selects the write-back value (ALU / DM / PC+8), commits it to the
// register file and serves the two asynchronous D-stage read ports.
// Optional feature macro: GRF_BYPASS_EN (same-cycle write-to-read bypass).
module wb_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_pc,
  input  logic [4:0]  W_GRF_WA,
  input  logic [31:0] W_ALU_result,
  input  logic [31:0] W_DM_RD,
  input  logic [1:0]  W_wd_sel,
  input  logic        W_we,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  output logic [31:0] D_rs_data,
  output logic [31:0] D_rt_data,
  output logic [31:0] W_GRF_WD,
  output logic        W_commit
);

  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_DM  = 2'b01;
  localparam logic [1:0] SEL_PC8 = 2'b10;

  // Register storage; entry 0 is held at zero by reset and never written.
  logic [31:0] regs_q [0:31];

  logic [31:0] wd_d;
  logic        commit_d;

  // Write-back data select; the reserved encoding yields zero.
  always_comb begin
    wd_d = 32'h0;
    case (W_wd_sel)
      SEL_ALU: wd_d = W_ALU_result;
      SEL_DM:  wd_d = W_DM_RD;
      SEL_PC8: wd_d = W_pc + 32'd8;
      default: wd_d = 32'h0;
    endcase
  end

  // A write lands only when enabled, not aimed at $0, and not under reset.
  assign commit_d = W_we && (W_GRF_WA != 5'd0) && !reset;

  assign W_GRF_WD = wd_d;
  assign W_commit = commit_d;

  // Register file update: reset clears everything and beats any write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else if (commit_d) begin
      regs_q[W_GRF_WA] <= wd_d;
    end
  end

  // Read port 1: $0 reads zero; optionally sees the in-flight write.
  always_comb begin
    D_rs_data = 32'h0;
    if (D_rs_addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
      if (commit_d && (D_rs_addr == W_GRF_WA)) begin
        D_rs_data = wd_d;
      end else begin
        D_rs_data = regs_q[D_rs_addr];
      end
`else
      D_rs_data = regs_q[D_rs_addr];
`endif
    end
  end

  // Read port 2: resolved independently of port 1 with the same rules.
  always_comb begin
    D_rt_data = 32'h0;
    if (D_rt_addr != 5'd0) begin
`ifdef GRF_BYPASS_EN
      if (commit_d && (D_rt_addr == W_GRF_WA)) begin
        D_rt_data = wd_d;
      end else begin
        D_rt_data = regs_q[D_rt_addr];
      end
`else
      D_rt_data = regs_q[D_rt_addr];
`endif
    end
  end

endmodule

// File: doc/wb_grf.md
# wb_grf

Write-back stage and general register file of the five-stage MIPS pipeline. The block consumes the W-stage pipeline register outputs (PC, destination register, ALU result, data-memory read data), selects the write-back value, and commits it to a 32×32-bit register file. It also serves the two combinational read ports used by the D stage. It exports the selected write-back value so the hazard and forwarding logic can bypass it to earlier stages.

## Interface
Parameters:
- none; widths are fixed by the ISA (32-bit data, 5-bit register address).

Ports:
- clk  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; clears every register.
- W_pc  input  32  PC of the instruction in W.
- W_GRF_WA  input  5  destination register of the W instruction.
- W_ALU_result  input  32  ALU result carried from M.
- W_DM_RD  input  32  data-memory read data carried from M.
- W_wd_sel  input  2  write-data select: 00 ALU, 01 DM, 10 PC+8, 11 reserved.
- W_we  input  1  write enable of the W instruction.
- D_rs_addr  input  5  read port 1 address.
- D_rt_addr  input  5  read port 2 address.
- D_rs_data  output  32  read port 1 data, combinational.
- D_rt_data  output  32  read port 2 data, combinational.
- W_GRF_WD  output  32  selected write-back data, combinational, used for forwarding.
- W_commit  output  1  high when a write actually lands this cycle (W_we and W_GRF_WA ≠ 0, reset low).

## Operation
- Write-data mux:
  - 00 → W_ALU_result.
  - 01 → W_DM_RD.
  - 10 → W_pc + 32'd8, modulo 2^32; 32'hFFFF_FFFC gives 32'h0000_0004.
  - 11 → 32'h0.
- Commit: on posedge clk, if reset is low, W_we = 1 and W_GRF_WA ≠ 0, then reg[W_GRF_WA] ← W_GRF_WD.
- Register 0:
  - Never written; always reads 32'h0.
  - A write with W_GRF_WA = 0 is dropped silently and W_commit stays 0.
- Reads are asynchronous: D_*_data = reg[D_*_addr], except address 0 returns 0. The exception is the bypass case in Configuration.
- Both read ports may address the same register, and the write register, in the same cycle. Each port resolves independently.
- W_we = 0: no state change, whatever the other W inputs hold.

## Timing
- Reset: on the posedge where reset = 1, all 32 registers become 32'h0. Reset wins over a simultaneous write.
  - Reads in the following cycle return 0 for every address.
  - W_GRF_WD and W_commit are combinational. W_commit is 0 while reset is high.
- Write latency: a value committed at edge N is visible on the read ports after edge N without bypass, i.e. during cycle N+1.
- Reset asserted mid-stream discards the in-flight W write at that edge. Writes resume at the first edge with reset low.
- No handshake: a W instruction is present for exactly one cycle. A stall or bubble upstream is signalled by W_we = 0.

## Configuration
- Macro GRF_BYPASS_EN:
  - Defined: internal write-to-read bypass. If W_we = 1, W_GRF_WA ≠ 0, reset = 0 and D_x_addr = W_GRF_WA, then D_x_data = W_GRF_WD in the same cycle. A read and write of the same register in one cycle therefore returns the new value.
  - Undefined: D_x_data returns the pre-edge register content. The hazard unit must forward W_GRF_WD to D explicitly.
- Nothing else changes between builds.

## Test plan
- Reset clear: write 32'hDEAD_BEEF to $5, then assert reset for one edge → D_rs_addr = 5 reads 32'h0, W_commit = 0 during reset.
- Write-data mux: W_pc = 32'h0000_3000, wd_sel = 10, WA = 31, we = 1 → after the edge $31 = 32'h0000_3008. Repeat with sel 00 (ALU 32'h1234) and sel 01 (DM 32'hCAFE) into $8 and $9. Check PC wrap with W_pc = 32'hFFFF_FFFC → 32'h4.
- Register 0: WA = 0, we = 1, data 32'hFFFF_FFFF → W_commit = 0, and reads of $0 on both ports stay 0.
- Same-cycle read/write: $3 = 32'h1, write 32'h2 to $3 while D_rs_addr = D_rt_addr = 3 → with GRF_BYPASS_EN both ports read 32'h2 in that cycle. Without it both read 32'h1, then 32'h2 in the next cycle.
- Write disabled: we = 0, WA = 7, ALU = 32'h55 → $7 unchanged, W_commit = 0, W_GRF_WD = 32'h55.
- Reset priority: reset = 1 and we = 1 to $4 with 32'hABCD on the same edge → $4 = 0 afterwards.
